set_mode_controller: RTL and testbench

SET_MODE_CONTROLLER -- requirements
Module: set_mode_controller

---
 rtl/clock_pkg.sv | 59 +++++
 rtl/key_repeat.sv | 55 +++++
 rtl/set_mode_controller.sv | 94 +++++++++
 tb/tb_set_mode_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the clock set-mode controller: state encoding,
// field bit positions, default timing and small counter helpers.
package clock_pkg;

   typedef enum logic [2:0] {
      RUN, S_HOUR, S_MIN, S_SEC, S_DAY, S_MONTH, S_YEAR
   } state_e;

   localparam int FLD_HOUR  = 0;
   localparam int FLD_MIN   = 1;
   localparam int FLD_SEC   = 2;
   localparam int FLD_DAY   = 3;
   localparam int FLD_MONTH = 4;
   localparam int FLD_YEAR  = 5;

   localparam int DEF_REPEAT_DELAY = 500;
   localparam int DEF_REPEAT_RATE  = 100;
   localparam int DEF_TIMEOUT      = 10000;
   localparam int DEF_BLINK_HALF   = 250;

   localparam int CNT_W = 16;

   function automatic logic [5:0] field_mask(input state_e s);
      logic [5:0] m;
      m = '0;
      case (s)
         S_HOUR:  m[FLD_HOUR]  = 1'b1;
         S_MIN:   m[FLD_MIN]   = 1'b1;
         S_SEC:   m[FLD_SEC]   = 1'b1;
         S_DAY:   m[FLD_DAY]   = 1'b1;
         S_MONTH: m[FLD_MONTH] = 1'b1;
         S_YEAR:  m[FLD_YEAR]  = 1'b1;
         default: m = '0;
      endcase
      return m;
   endfunction

   function automatic state_e next_field(input state_e s);
      case (s)
         RUN:     return S_HOUR;
         S_HOUR:  return S_MIN;
         S_MIN:   return S_SEC;
         S_SEC:   return S_DAY;
         S_DAY:   return S_MONTH;
         S_MONTH: return S_YEAR;
         default: return RUN;
      endcase
   endfunction

   // Saturating increment: a stuck counter can never wrap back into a trigger window.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   function automatic logic reached(input logic [CNT_W-1:0] c, input int lim);
      return {16'd0, c} >= lim[31:0];
   endfunction

endpackage

// File: rtl/key_repeat.sv
// Per-key rising-edge detect and auto-repeat timer; clr kills any pending repeat
// and forces a fresh press before the key can repeat again.
module key_repeat
   import clock_pkg::*;
#(
   parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
   input  logic clk,
   input  logic rst,
   input  logic armed,
   input  logic tick_ms,
   input  logic key,
   input  logic clr,
   output logic rise,
   output logic fire
);

   logic             prev, held, rep, rep_hit;
   logic [CNT_W-1:0] cnt;

   always_comb begin
      rise    = key & ~prev & armed;
      rep_hit = held & key & tick_ms &
                reached(sat_inc(cnt), rep ? REPEAT_RATE : REPEAT_DELAY);
      fire    = ~clr & (rise | rep_hit);
   end

   // held only set by an accepted press, so a key carried over a clear stays silent
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev <= 1'b0;
         held <= 1'b0;
         rep  <= 1'b0;
         cnt  <= '0;
      end else begin
         prev <= key;
         if (clr || !key) begin
            held <= 1'b0;
            rep  <= 1'b0;
            cnt  <= '0;
         end else if (rise) begin
            held <= 1'b1;
            rep  <= 1'b0;
            cnt  <= '0;
         end else if (rep_hit) begin
            rep  <= 1'b1;
            cnt  <= '0;
         end else if (held && tick_ms) begin
            cnt  <= sat_inc(cnt);
         end
      end
   end

endmodule

// File: rtl/set_mode_controller.sv
// Clock set-mode FSM: mode key walks the editable fields, up/down keys emit
// edit pulses with auto-repeat, the selected field blinks, idle returns to RUN.
module set_mode_controller
   import clock_pkg::*;
#(
   parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
   parameter int TIMEOUT      = DEF_TIMEOUT,
   parameter int BLINK_HALF   = DEF_BLINK_HALF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_ms,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic [5:0] manual_set,
   output logic       up,
   output logic       down,
   output logic       blink,
   output logic       setting
);

   state_e           state, nxt;
   logic             armed, mode_prev, mode_rise, in_set, timeout_hit, clr;
   logic             up_rise, up_fire, dn_rise, dn_fire;
   logic [CNT_W-1:0] idle_cnt, blink_cnt;

   // Timeout outranks the mode key; any state change or key conflict clears repeats.
   always_comb begin
      mode_rise   = btn_mode & ~mode_prev & armed;
      in_set      = (state != RUN);
      timeout_hit = in_set & reached(idle_cnt, TIMEOUT);
      nxt         = state;
      if (timeout_hit)    nxt = RUN;
      else if (mode_rise) nxt = next_field(state);
      clr = ~in_set | mode_rise | timeout_hit | (btn_up & btn_down);
   end

   key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_up (
      .clk(clk), .rst(rst), .armed(armed), .tick_ms(tick_ms),
      .key(btn_up), .clr(clr), .rise(up_rise), .fire(up_fire)
   );

   key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_down (
      .clk(clk), .rst(rst), .armed(armed), .tick_ms(tick_ms),
      .key(btn_down), .clr(clr), .rise(dn_rise), .fire(dn_fire)
   );

   // armed masks edges on the first cycle out of reset so a held key is not a press
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RUN;
         armed      <= 1'b0;
         mode_prev  <= 1'b0;
         idle_cnt   <= '0;
         blink_cnt  <= '0;
         manual_set <= '0;
         up         <= 1'b0;
         down       <= 1'b0;
         blink      <= 1'b0;
         setting    <= 1'b0;
      end else begin
         armed      <= 1'b1;
         mode_prev  <= btn_mode;
         state      <= nxt;
         setting    <= (nxt != RUN);
         manual_set <= field_mask(nxt);
         up         <= up_fire;
         down       <= dn_fire;

         if (nxt != state || !in_set || mode_rise || up_rise || dn_rise)
            idle_cnt <= '0;
         else if (tick_ms)
            idle_cnt <= sat_inc(idle_cnt);

         if (nxt == RUN) begin
            blink     <= 1'b0;
            blink_cnt <= '0;
         end else if (nxt != state || up_fire || dn_fire) begin
            blink     <= 1'b1;
            blink_cnt <= '0;
         end else if (tick_ms) begin
            if (reached(sat_inc(blink_cnt), BLINK_HALF)) begin
               blink     <= ~blink;
               blink_cnt <= '0;
            end else begin
               blink_cnt <= sat_inc(blink_cnt);
            end
         end
      end
   end

endmodule

// File: tb/tb_set_mode_controller.sv
// Scoreboard bench: stimulus pushes expected outputs from a tick-level reference
// model, a monitor pops and compares every clock.
module tb_set_mode_controller;
   import clock_pkg::*;

   localparam int RD = 500;
   localparam int RR = 100;
   localparam int TO = 10000;
   localparam int BH = 250;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick_ms = 1'b0, btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
   logic [5:0] manual_set;
   logic       up, down, blink, setting;

   int tests = 0;
   int fails = 0;
   int up_seen = 0;
   int dn_seen = 0;
   int cyc_n = 0;

   typedef struct packed {
      logic [5:0] ms;
      logic       up;
      logic       dn;
      logic       bl;
      logic       st;
   } exp_t;
   exp_t expq[$];

   set_mode_controller #(
      .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TIMEOUT(TO), .BLINK_HALF(BH)
   ) dut (
      .clk(clk), .rst(rst), .tick_ms(tick_ms), .btn_mode(btn_mode),
      .btn_up(btn_up), .btn_down(btn_down), .manual_set(manual_set),
      .up(up), .down(down), .blink(blink), .setting(setting)
   );

   always #5 clk = ~clk;

   // Reference model: state index 0=RUN, k=field k-1; hold times in whole ticks.
   int m_st, m_uh, m_dh, m_idle, m_bt;
   bit m_armed, m_pm, m_pu, m_pd;

   function automatic bit pulse_due(int n);
      return (n == RD) || (n > RD && ((n - RD) % RR) == 0);
   endfunction

   task automatic model_reset();
      m_st = 0; m_uh = -1; m_dh = -1; m_idle = 0; m_bt = 0;
      m_armed = 0; m_pm = 0; m_pu = 0; m_pd = 0;
   endtask

   task automatic model_step(bit r, bit md, bit u, bit d, bit t);
      exp_t e;
      bit mr, ur, dr, ins, tmo, clr, fu, fd;
      int nst;
      e = '0;
      if (r) begin
         model_reset();
         expq.push_back(e);
         return;
      end
      mr  = md && !m_pm && m_armed;
      ur  = u && !m_pu && m_armed;
      dr  = d && !m_pd && m_armed;
      ins = (m_st != 0);
      tmo = ins && (m_idle >= TO);
      nst = tmo ? 0 : (mr ? (m_st + 1) % 7 : m_st);
      clr = !ins || mr || tmo || (u && d);
      fu  = !clr && (ur || (u && m_uh >= 0 && t && pulse_due(m_uh + 1)));
      fd  = !clr && (dr || (d && m_dh >= 0 && t && pulse_due(m_dh + 1)));
      if (clr || !u) m_uh = -1; else if (ur) m_uh = 0; else if (m_uh >= 0 && t) m_uh++;
      if (clr || !d) m_dh = -1; else if (dr) m_dh = 0; else if (m_dh >= 0 && t) m_dh++;
      if (nst != m_st || !ins || mr || ur || dr) m_idle = 0; else if (t) m_idle++;
      if (nst == 0 || nst != m_st || fu || fd) m_bt = 0; else if (t) m_bt++;
      e.ms = (nst == 0) ? 6'd0 : 6'(1 << (nst - 1));
      e.up = fu;
      e.dn = fd;
      e.bl = (nst != 0) && (((m_bt / BH) % 2) == 0);
      e.st = (nst != 0);
      m_st = nst; m_pm = md; m_pu = u; m_pd = d; m_armed = 1;
      expq.push_back(e);
   endtask

   always @(posedge clk) begin : mon
      exp_t e;
      exp_t got;
      #1;
      got = {manual_set, up, down, blink, setting};
      if (expq.size() > 0) begin
         e = expq.pop_front();
         tests++;
         if (got !== e) begin
            fails++;
            $display("FAIL outputs cyc=%0d got ms=%b up=%b dn=%b bl=%b st=%b exp ms=%b up=%b dn=%b bl=%b st=%b",
                     cyc_n, got.ms, got.up, got.dn, got.bl, got.st, e.ms, e.up, e.dn, e.bl, e.st);
         end
      end
      if (up) up_seen++;
      if (down) dn_seen++;
   end

   task automatic chk(string nm, int got, int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   // Called at a negedge: drive inputs, predict, advance to the next negedge.
   task automatic cyc(bit md, bit u, bit d);
      btn_mode = md; btn_up = u; btn_down = d;
      tick_ms  = cyc_n[0];
      model_step(rst, md, u, d, tick_ms);
      cyc_n++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) cyc(0, 0, 0);
      rst = 1'b0;
      repeat (2) cyc(0, 0, 0);
   endtask

   task automatic press_mode();
      cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
   endtask

   initial begin
      int u0, d0, left;
      bit md, u, d;
      model_reset();
      @(negedge clk);
      repeat (3) cyc(0, 0, 0);
      chk("reset_outputs", int'({manual_set, up, down, blink, setting}), 0);
      rst = 1'b0;
      repeat (2) cyc(0, 0, 0);

      // one mode press then a short up press
      press_mode();
      chk("hour_selected", int'(manual_set), 1);
      u0 = up_seen;
      cyc(0, 1, 0);
      chk("up_latency", int'(up), 1);
      cyc(0, 1, 0);
      chk("up_single_width", int'(up), 0);
      cyc(0, 1, 0);
      repeat (2) cyc(0, 0, 0);
      chk("up_one_pulse", up_seen - u0, 1);

      // auto-repeat in S_MIN over 1000+ ticks
      press_mode();
      chk("min_selected", int'(manual_set), 2);
      u0 = up_seen;
      repeat (2004) cyc(0, 1, 0);
      repeat (2) cyc(0, 0, 0);
      chk("repeat_count", up_seen - u0, 7);

      // full mode cycle, then up in RUN
      do_reset();
      for (int i = 0; i < 7; i++) begin
         press_mode();
         chk("mode_walk", int'(manual_set), (i < 6) ? (1 << i) : 0);
      end
      chk("walk_setting", int'(setting), 0);
      u0 = up_seen;
      repeat (3) begin cyc(0, 1, 0); cyc(0, 0, 0); end
      chk("run_ignores_up", up_seen - u0, 0);

      // both keys in S_DAY, then inactivity timeout
      repeat (4) press_mode();
      chk("day_selected", int'(manual_set), 8);
      u0 = up_seen; d0 = dn_seen;
      repeat (5) cyc(0, 1, 1);
      cyc(0, 0, 0);
      chk("both_no_pulse", (up_seen - u0) + (dn_seen - d0), 0);
      repeat (19900) cyc(0, 0, 0);
      chk("before_timeout", int'(setting), 1);
      repeat (200) cyc(0, 0, 0);
      chk("after_timeout", int'({manual_set, setting}), 0);

      // reset during auto-repeat in S_YEAR
      do_reset();
      repeat (6) press_mode();
      chk("year_selected", int'(manual_set), 32);
      repeat (1300) cyc(0, 1, 0);
      rst = 1'b1;
      #1;
      chk("async_reset", int'({manual_set, up, down, blink, setting}), 0);
      u0 = up_seen;
      repeat (2) cyc(0, 1, 0);
      rst = 1'b0;
      repeat (2000) cyc(0, 1, 0);
      cyc(0, 0, 0);
      chk("held_through_reset", up_seen - u0, 0);

      // randomized key traffic against the model
      do_reset();
      left = 0; md = 0; u = 0; d = 0;
      repeat (6000) begin
         if (left == 0) begin
            md   = ($urandom_range(0, 7) == 0);
            u    = 1'($urandom_range(0, 1));
            d    = ($urandom_range(0, 3) == 0);
            left = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1000, 1300))
                                               : int'($urandom_range(1, 30));
         end
         cyc(md, u, d);
         left--;
      end
      repeat (3) cyc(0, 0, 0);
      chk("queue_drained", expq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
